// File: rtl/n_to_1_mux_pkg.sv
// Shared definitions for the N-to-1 bit multiplexer: select-width derivation,
// the select range check and the registered output bundle.
package n_to_1_mux_pkg;

    // Legal range and default for the number of data inputs.
    localparam int N_MIN     = 1;
    localparam int N_MAX     = 256;
    localparam int N_DEFAULT = 8;

    // Select width for n inputs. A one-input mux still carries a 1-bit
    // select, so the result is clamped to at least one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // True when sel_val addresses one of the n real inputs. The 4-state
    // argument lets an unknown select give an unknown answer instead of
    // being quietly collapsed to zero.
    function automatic logic sel_in_range(input logic [31:0] sel_val,
                                          input logic [31:0] n);
        return sel_val < n;
    endfunction

    // Registered outputs of the top level, kept together so reset clears
    // them as one unit.
    typedef struct packed {
        logic out_q;
        logic out_valid;
        logic sel_err;
    } mux_regs_t;

endpackage

// File: rtl/n_to_1_mux_if.sv
// Bus between the mux and whatever drives it: data/select/qualifier in,
// combinational and registered results out.
interface n_to_1_mux_if
    import n_to_1_mux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int SEL_W = sel_width(N)
) ();

    logic [N-1:0]     data;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             out;
    logic             out_q;
    logic             out_valid;
    logic             sel_err;

    // Driver side: supplies the candidates and the select.
    modport master (
        output data,
        output sel,
        output in_valid,
        input  out,
        input  out_q,
        input  out_valid,
        input  sel_err
    );

    // Mux side.
    modport slave (
        input  data,
        input  sel,
        input  in_valid,
        output out,
        output out_q,
        output out_valid,
        output sel_err
    );

endinterface

// File: rtl/n_to_1_mux_core.sv
// Purely combinational core: routes data[sel] to out and flags selects that
// point past the last real input. Out-of-range selects give out = 0.
module n_to_1_mux_core
    import n_to_1_mux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     data,
    input  logic [SEL_W-1:0] sel,
    output logic             out,
    output logic             sel_err
);

    // Every select code gets a slot, so the index never leaves the vector.
    localparam int PAD_W = 1 << SEL_W;

    logic [PAD_W-1:0] data_pad;
    logic             in_range;

    // Zero-extend the inputs up to the full select space; the unused top
    // slots are never routed because the range check masks them.
    always_comb begin
        data_pad         = '0;
        data_pad[N-1:0]  = data;
    end

    // Select and range check. The ternary (rather than an if) keeps an
    // unknown select visible as X on out instead of steering it to 0.
    always_comb begin
        in_range = sel_in_range(32'(sel), 32'(N));
        sel_err  = ~in_range;
        out      = in_range ? data_pad[sel] : 1'b0;
    end

endmodule

// File: rtl/n_to_1_mux.sv
// N-to-1 bit multiplexer: combinational select from the core plus a one-
// cycle registered copy with its qualifier and an out-of-range flag.
module n_to_1_mux
    import n_to_1_mux_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int SEL_W = sel_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    n_to_1_mux_if.slave  bus
);

    logic      core_out;
    logic      core_err;
    mux_regs_t regs;

    n_to_1_mux_core #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_core (
        .data    (bus.data),
        .sel     (bus.sel),
        .out     (core_out),
        .sel_err (core_err)
    );

    // The combinational result is live even while reset is held.
    assign bus.out = core_out;

    // Capture the selected bit and range flag on valid cycles; on idle
    // cycles only the qualifier drops, the data and flag hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            regs.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                regs.out_q   <= core_out;
                regs.sel_err <= core_err;
            end
        end
    end

    assign bus.out_q     = regs.out_q;
    assign bus.out_valid = regs.out_valid;
    assign bus.sel_err   = regs.sel_err;

endmodule

// File: tb/tb_n_to_1_mux.sv
// Directed and randomised checks of n_to_1_mux across several widths
// (N = 1, 3, 5, 8, 16) sharing one clock and reset.
module tb_n_to_1_mux;
    import n_to_1_mux_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    n_to_1_mux_if #(.N(1))  if1  ();
    n_to_1_mux_if #(.N(3))  if3  ();
    n_to_1_mux_if #(.N(5))  if5  ();
    n_to_1_mux_if #(.N(8))  if8  ();
    n_to_1_mux_if #(.N(16)) if16 ();

    n_to_1_mux #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    n_to_1_mux #(.N(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(if3));
    n_to_1_mux #(.N(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(if5));
    n_to_1_mux #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    n_to_1_mux #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one DUT's inputs; which is that DUT's N.
    task automatic applyStimulus(input int which, input logic [31:0] d,
                                 input int s, input logic v);
        case (which)
            1:  begin if1.data  = d[0:0];  if1.sel  = 1'(s); if1.in_valid  = v; end
            3:  begin if3.data  = d[2:0];  if3.sel  = 2'(s); if3.in_valid  = v; end
            5:  begin if5.data  = d[4:0];  if5.sel  = 3'(s); if5.in_valid  = v; end
            8:  begin if8.data  = d[7:0];  if8.sel  = 3'(s); if8.in_valid  = v; end
            16: begin if16.data = d[15:0]; if16.sel = 4'(s); if16.in_valid = v; end
            default: ;
        endcase
    endtask

    // Sample one DUT's outputs.
    task automatic readOutputs(input int which, output logic o, output logic q,
                               output logic v, output logic e);
        case (which)
            1:  begin o = if1.out;  q = if1.out_q;  v = if1.out_valid;  e = if1.sel_err;  end
            3:  begin o = if3.out;  q = if3.out_q;  v = if3.out_valid;  e = if3.sel_err;  end
            5:  begin o = if5.out;  q = if5.out_q;  v = if5.out_valid;  e = if5.sel_err;  end
            8:  begin o = if8.out;  q = if8.out_q;  v = if8.out_valid;  e = if8.sel_err;  end
            16: begin o = if16.out; q = if16.out_q; v = if16.out_valid; e = if16.sel_err; end
            default: begin o = 1'bx; q = 1'bx; v = 1'bx; e = 1'bx; end
        endcase
    endtask

    // Single comparison point: counts every vector and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // One full cycle on one DUT: drive at the falling edge, check the
    // combinational output, then check the registers just after the next
    // rising edge.
    task automatic runVector(input string tag, input int which, input logic [31:0] d,
                             input int s, input logic v, input logic exp_out,
                             input logic exp_q, input logic exp_v, input logic exp_e);
        logic o, q, ov, e;
        @(negedge clk);
        applyStimulus(which, d, s, v);
        #1;
        readOutputs(which, o, q, ov, e);
        checkOutput({tag, "_out"}, 32'(o), 32'(exp_out));
        @(posedge clk);
        #1;
        readOutputs(which, o, q, ov, e);
        checkOutput({tag, "_out_q"}, 32'(q), 32'(exp_q));
        checkOutput({tag, "_out_valid"}, 32'(ov), 32'(exp_v));
        checkOutput({tag, "_sel_err"}, 32'(e), 32'(exp_e));
    endtask

    initial begin
        logic o, q, ov, e;
        int   exp29 [8] = '{1, 1, 1, 0, 1, 0, 1, 1};
        int   nlist [3] = '{3, 8, 16};
        int   wlist [3] = '{2, 3, 4};
        logic [31:0] rd [3];
        int          rs [3];
        logic        rv [3];
        logic        mo [3];
        logic        mq [3];
        logic        me [3];

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(1, 0, 0, 1'b0);
        applyStimulus(3, 0, 0, 1'b0);
        applyStimulus(5, 0, 0, 1'b0);
        applyStimulus(8, 0, 0, 1'b0);
        applyStimulus(16, 0, 0, 1'b0);

        // Reset state of the registered outputs.
        #12;
        readOutputs(8, o, q, ov, e);
        checkOutput("rst_out_q", 32'(q), 32'd0);
        checkOutput("rst_out_valid", 32'(ov), 32'd0);
        checkOutput("rst_sel_err", 32'(e), 32'd0);
        readOutputs(5, o, q, ov, e);
        checkOutput("rst5_out_valid", 32'(ov), 32'd0);

        // Combinational path works under reset; registers stay cleared.
        applyStimulus(8, 32'h04, 2, 1'b1);
        #1;
        readOutputs(8, o, q, ov, e);
        checkOutput("rst_comb_out", 32'(o), 32'd1);
        @(posedge clk);
        #1;
        readOutputs(8, o, q, ov, e);
        checkOutput("rst_hold_valid", 32'(ov), 32'd0);
        checkOutput("rst_hold_out_q", 32'(q), 32'd0);

        // Release away from the clock edge with nothing valid pending.
        @(negedge clk);
        applyStimulus(8, 0, 0, 1'b0);
        rst_n = 1'b1;

        // N=8 walk of sel over 8'b11010111, back to back.
        for (int i = 0; i < 8; i++)
            runVector($sformatf("walk%0d", i), 8, 32'hD7, i, 1'b1,
                      1'(exp29[i]), 1'(exp29[i]), 1'b1, 1'b0);

        // N=5 out-of-range selects, then the top real input.
        runVector("n5_sel5", 5, 32'h16, 5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("n5_sel6", 5, 32'h16, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("n5_sel7", 5, 32'h16, 7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("n5_sel4", 5, 32'h16, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runVector("n5_idle", 5, 32'h16, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Valid gap: out_q holds its captured 1 while data drops.
        runVector("gap_v1", 8, 32'h08, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runVector("gap_v0", 8, 32'h00, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        runVector("gap_v2", 8, 32'h08, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-cycle asynchronous reset with out_q=1, out_valid=1.
        #2;
        rst_n = 1'b0;
        applyStimulus(8, 32'h08, 3, 1'b0);
        #1;
        readOutputs(8, o, q, ov, e);
        checkOutput("async_out_q", 32'(q), 32'd0);
        checkOutput("async_out_valid", 32'(ov), 32'd0);
        checkOutput("async_comb_out", 32'(o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            readOutputs(8, o, q, ov, e);
            checkOutput($sformatf("post_rst%0d_valid", i), 32'(ov), 32'd0);
            checkOutput($sformatf("post_rst%0d_out_q", i), 32'(q), 32'd0);
        end
        runVector("post_rst_new", 8, 32'h08, 3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runVector("post_rst_idle", 8, 32'h08, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // N=1: the only real input, then the single out-of-range code.
        runVector("n1_sel0", 1, 32'h1, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        runVector("n1_sel1", 1, 32'h1, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        runVector("n1_idle", 1, 32'h1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random stress on N = 3, 8, 16 in parallel against a bit-select
        // model. The first cycle is forced valid so the held model state
        // starts known.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rd[k] = $urandom;
                rs[k] = int'($urandom_range(0, (1 << wlist[k]) - 1));
                rv[k] = (cyc == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                mo[k] = (rs[k] < nlist[k]) ? rd[k][rs[k]] : 1'b0;
                applyStimulus(nlist[k], rd[k], rs[k], rv[k]);
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                readOutputs(nlist[k], o, q, ov, e);
                checkOutput($sformatf("rnd_n%0d_out", nlist[k]), 32'(o), 32'(mo[k]));
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rv[k]) begin
                    mq[k] = mo[k];
                    me[k] = (rs[k] >= nlist[k]);
                end
                readOutputs(nlist[k], o, q, ov, e);
                checkOutput($sformatf("rnd_n%0d_valid", nlist[k]), 32'(ov), 32'(rv[k]));
                checkOutput($sformatf("rnd_n%0d_out_q", nlist[k]), 32'(q), 32'(mq[k]));
                checkOutput($sformatf("rnd_n%0d_sel_err", nlist[k]), 32'(e), 32'(me[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
